// File: rtl/pixel_write_buffer_if.sv
// pixel_write_buffer_if: raster-core pixel handshake and SRAM write port bundle
interface pixel_write_buffer_if;
  logic data_ready;
  logic [18:0] address;
  logic [15:0] color;
  logic frame_target;
  logic data_sent;
  logic sram_wr_req;
  logic [19:0] sram_addr;
  logic [15:0] sram_wdata;
  logic sram_wr_ack;
  logic idle;
  logic [7:0] drop_count;
  modport master (
    output data_ready, address, color, frame_target, sram_wr_ack,
    input data_sent, sram_wr_req, sram_addr, sram_wdata, idle, drop_count
  );
  modport slave (
    input data_ready, address, color, frame_target, sram_wr_ack,
    output data_sent, sram_wr_req, sram_addr, sram_wdata, idle, drop_count
  );
endinterface

// File: rtl/pixel_write_buffer.sv
// pixel_write_buffer: FIFO from raster core to SRAM write port, discarding and counting off-screen pixels
module pixel_write_buffer #(
  parameter int DEPTH = 8,
  parameter int PIX_LIMIT = 307200
) (
  input logic clk,
  input logic n_rst,
  pixel_write_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [18:0] LIMIT = 19'(PIX_LIMIT);
  typedef enum logic {IDLE, WRITE} state_t;
  state_t state, state_nxt;
  logic [35:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic in_range, take, push, pop, load;
  assign in_range = bus.address < LIMIT;
  // Out-of-range pixels are taken even when full since they never occupy a slot
  assign take = bus.data_ready & ~bus.data_sent & ((count != (AW+1)'(DEPTH)) | ~in_range);
  assign push = take & in_range;
  assign pop = (state == WRITE) & bus.sram_wr_ack;
  assign load = (state == IDLE) & (count != '0);
  assign bus.sram_wr_req = state == WRITE;
  assign bus.idle = (count == '0) & (state == IDLE);
  always_comb begin
    state_nxt = state;
    state_nxt = load ? WRITE : pop ? IDLE : state;
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {bus.frame_target, bus.address, bus.color};
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      bus.data_sent <= 1'b0;
      bus.drop_count <= '0;
      bus.sram_addr <= '0;
      bus.sram_wdata <= '0;
    end else begin
      bus.data_sent <= take;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (take & ~in_range & ~&bus.drop_count) bus.drop_count <= bus.drop_count + 8'd1;
      if (load) {bus.sram_addr, bus.sram_wdata} <= mem[rd_ptr];
    end
endmodule

// File: tb/tb_pixel_write_buffer.sv
// tb_pixel_write_buffer: directed checks of capture, drop counting, FIFO ordering and SRAM handshake timing
module tb_pixel_write_buffer;
  logic tb_clk = 1'b0;
  logic n_rst = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [19:0] got_addr[$];
  logic [15:0] got_data[$];
  int sent_cyc[$];
  int wr_cyc[$];
  int occ_max;
  pixel_write_buffer_if bus();
  pixel_write_buffer #(.DEPTH(8), .PIX_LIMIT(307200)) dut (
    .clk(tb_clk),
    .n_rst(n_rst),
    .bus(bus.slave)
  );
  always #5 tb_clk = ~tb_clk;

  task automatic step;
    @(posedge tb_clk);
    #1;
  endtask

  task automatic offer(input logic [18:0] a, input logic [15:0] c, input logic f);
    bus.address = a;
    bus.color = c;
    bus.frame_target = f;
    bus.data_ready = 1'b1;
  endtask

  task automatic drain(input int n);
    got_addr.delete();
    got_data.delete();
    bus.sram_wr_ack = 1'b0;
    for (int c = 0; c < 200 && got_data.size() < n; c++) begin
      if (bus.sram_wr_req && !bus.sram_wr_ack) begin
        got_addr.push_back(bus.sram_addr);
        got_data.push_back(bus.sram_wdata);
        bus.sram_wr_ack = 1'b1;
      end else bus.sram_wr_ack = 1'b0;
      step;
    end
    bus.sram_wr_ack = 1'b0;
  endtask

  task automatic run_stream(input int n, input logic [18:0] a0, input logic [15:0] c0);
    int p = 0;
    int acc = 0;
    int done = 0;
    got_addr.delete();
    got_data.delete();
    sent_cyc.delete();
    wr_cyc.delete();
    occ_max = 0;
    bus.sram_wr_ack = 1'b0;
    offer(a0, c0, 1'b0);
    for (int c = 0; c < 400 && done < n; c++) begin
      step;
      if (bus.sram_wr_ack) done++;
      if (bus.data_sent) begin
        sent_cyc.push_back(c);
        acc++;
        p++;
        if (p < n) offer(a0 + 19'(p), c0 + 16'(p), p[0]);
        else bus.data_ready = 1'b0;
      end
      if (acc - done > occ_max) occ_max = acc - done;
      if (bus.sram_wr_req && !bus.sram_wr_ack) begin
        got_addr.push_back(bus.sram_addr);
        got_data.push_back(bus.sram_wdata);
        wr_cyc.push_back(c);
        bus.sram_wr_ack = 1'b1;
      end else bus.sram_wr_ack = 1'b0;
    end
    bus.sram_wr_ack = 1'b0;
    bus.data_ready = 1'b0;
  endtask

  task automatic test_reset;
    bus.data_ready = 1'b0;
    bus.address = '0;
    bus.color = '0;
    bus.frame_target = 1'b0;
    bus.sram_wr_ack = 1'b0;
    n_rst = 1'b0;
    repeat (3) step;
    vectors++; if (bus.sram_wr_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", bus.sram_wr_req); end
    vectors++; if (bus.data_sent !== 1'b0) begin miscompares++; $display("FAIL reset_sent: got %b want 0", bus.data_sent); end
    vectors++; if (bus.idle !== 1'b1) begin miscompares++; $display("FAIL reset_idle: got %b want 1", bus.idle); end
    vectors++; if (bus.drop_count !== 8'd0) begin miscompares++; $display("FAIL reset_drop: got %0d want 0", bus.drop_count); end
    vectors++; if (bus.sram_addr !== 20'h0) begin miscompares++; $display("FAIL reset_addr: got %h want 0", bus.sram_addr); end
    n_rst = 1'b1;
    step;
  endtask

  task automatic test_single;
    offer(19'd200, 16'h0060, 1'b1);
    step;
    bus.data_ready = 1'b0;
    vectors++; if (bus.data_sent !== 1'b1) begin miscompares++; $display("FAIL single_sent: got %b want 1", bus.data_sent); end
    vectors++; if (bus.sram_wr_req !== 1'b0) begin miscompares++; $display("FAIL single_req_early: got %b want 0", bus.sram_wr_req); end
    step;
    vectors++; if (bus.data_sent !== 1'b0) begin miscompares++; $display("FAIL single_sent_pulse: got %b want 0", bus.data_sent); end
    vectors++; if (bus.sram_wr_req !== 1'b1) begin miscompares++; $display("FAIL single_req: got %b want 1", bus.sram_wr_req); end
    for (int i = 0; i < 3; i++) begin
      vectors++; if (bus.sram_addr !== 20'h800C8) begin miscompares++; $display("FAIL single_addr%0d: got %h want 800c8", i, bus.sram_addr); end
      vectors++; if (bus.sram_wdata !== 16'h0060) begin miscompares++; $display("FAIL single_data%0d: got %h want 0060", i, bus.sram_wdata); end
      if (i < 2) step;
    end
    bus.sram_wr_ack = 1'b1;
    step;
    bus.sram_wr_ack = 1'b0;
    vectors++; if (bus.sram_wr_req !== 1'b0) begin miscompares++; $display("FAIL single_req_drop: got %b want 0", bus.sram_wr_req); end
    vectors++; if (bus.idle !== 1'b1) begin miscompares++; $display("FAIL single_idle: got %b want 1", bus.idle); end
  endtask

  task automatic test_fill;
    int p = 0;
    int pulses = 0;
    bus.sram_wr_ack = 1'b0;
    offer(19'd100, 16'h1000, 1'b0);
    for (int i = 0; i < 30; i++) begin
      step;
      if (bus.data_sent) begin
        pulses++;
        p++;
        offer(19'(100 + p * 7), 16'(16'h1000 + p), 1'b0);
      end
    end
    vectors++; if (pulses !== 8) begin miscompares++; $display("FAIL fill_pulses: got %0d want 8", pulses); end
    vectors++; if (bus.data_sent !== 1'b0) begin miscompares++; $display("FAIL fill_hold: got %b want 0", bus.data_sent); end
    vectors++; if (bus.sram_addr !== 20'd100) begin miscompares++; $display("FAIL fill_head: got %h want %h", bus.sram_addr, 20'd100); end
    bus.sram_wr_ack = 1'b1;
    step;
    bus.sram_wr_ack = 1'b0;
    vectors++; if (bus.data_sent !== 1'b0) begin miscompares++; $display("FAIL fill_pop_edge: got %b want 0", bus.data_sent); end
    step;
    bus.data_ready = 1'b0;
    vectors++; if (bus.data_sent !== 1'b1) begin miscompares++; $display("FAIL fill_ninth: got %b want 1", bus.data_sent); end
    vectors++; if (bus.sram_addr !== 20'd107) begin miscompares++; $display("FAIL fill_next_head: got %h want %h", bus.sram_addr, 20'd107); end
    drain(8);
    vectors++; if (got_data.size() !== 8) begin miscompares++; $display("FAIL fill_writes: got %0d want 8", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      vectors++; if (got_data[i] !== 16'(16'h1001 + i)) begin miscompares++; $display("FAIL fill_order%0d: got %h want %h", i, got_data[i], 16'(16'h1001 + i)); end
    end
    vectors++; if (bus.idle !== 1'b1) begin miscompares++; $display("FAIL fill_idle: got %b want 1", bus.idle); end
  endtask

  task automatic test_out_of_range;
    offer(19'd307200, 16'hFFFF, 1'b0);
    step;
    bus.data_ready = 1'b0;
    vectors++; if (bus.data_sent !== 1'b1) begin miscompares++; $display("FAIL oor1_sent: got %b want 1", bus.data_sent); end
    vectors++; if (bus.drop_count !== 8'd1) begin miscompares++; $display("FAIL oor1_drop: got %0d want 1", bus.drop_count); end
    step;
    offer(19'd524287, 16'h1234, 1'b1);
    step;
    bus.data_ready = 1'b0;
    vectors++; if (bus.data_sent !== 1'b1) begin miscompares++; $display("FAIL oor2_sent: got %b want 1", bus.data_sent); end
    vectors++; if (bus.drop_count !== 8'd2) begin miscompares++; $display("FAIL oor2_drop: got %0d want 2", bus.drop_count); end
    step;
    vectors++; if (bus.sram_wr_req !== 1'b0) begin miscompares++; $display("FAIL oor_req: got %b want 0", bus.sram_wr_req); end
    vectors++; if (bus.idle !== 1'b1) begin miscompares++; $display("FAIL oor_idle: got %b want 1", bus.idle); end
    offer(19'd400000, 16'h0001, 1'b0);
    repeat (504) step;
    vectors++; if (bus.drop_count !== 8'd254) begin miscompares++; $display("FAIL oor_drop254: got %0d want 254", bus.drop_count); end
    repeat (92) step;
    bus.data_ready = 1'b0;
    step;
    vectors++; if (bus.drop_count !== 8'd255) begin miscompares++; $display("FAIL oor_saturate: got %0d want 255", bus.drop_count); end
    vectors++; if (bus.idle !== 1'b1) begin miscompares++; $display("FAIL oor_idle_end: got %b want 1", bus.idle); end
  endtask

  task automatic test_wrap;
    run_stream(20, 19'd1000, 16'h0100);
    vectors++; if (got_data.size() !== 20) begin miscompares++; $display("FAIL wrap_writes: got %0d want 20", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      vectors++; if (got_data[i] !== 16'(16'h0100 + i)) begin miscompares++; $display("FAIL wrap_data%0d: got %h want %h", i, got_data[i], 16'(16'h0100 + i)); end
      vectors++; if (got_addr[i] !== {i[0], 19'(1000 + i)}) begin miscompares++; $display("FAIL wrap_addr%0d: got %h want %h", i, got_addr[i], {i[0], 19'(1000 + i)}); end
    end
    step;
    vectors++; if (bus.idle !== 1'b1) begin miscompares++; $display("FAIL wrap_idle: got %b want 1", bus.idle); end
  endtask

  task automatic test_back_to_back;
    int bad_in = 0;
    int bad_out = 0;
    run_stream(12, 19'd307000, 16'hA000);
    vectors++; if (wr_cyc.size() !== 12) begin miscompares++; $display("FAIL b2b_writes: got %0d want 12", wr_cyc.size()); end
    for (int i = 1; i < sent_cyc.size(); i++) if (sent_cyc[i] - sent_cyc[i-1] != 2) bad_in++;
    for (int i = 1; i < wr_cyc.size(); i++) if (wr_cyc[i] - wr_cyc[i-1] != 2) bad_out++;
    vectors++; if (bad_in !== 0) begin miscompares++; $display("FAIL b2b_in_spacing: got %0d gaps not 2 want 0", bad_in); end
    vectors++; if (bad_out !== 0) begin miscompares++; $display("FAIL b2b_out_spacing: got %0d gaps not 2 want 0", bad_out); end
    if (sent_cyc.size() > 0 && wr_cyc.size() > 0) begin
      vectors++; if (wr_cyc[0] !== sent_cyc[0] + 1) begin miscompares++; $display("FAIL b2b_latency: got req at %0d want %0d", wr_cyc[0], sent_cyc[0] + 1); end
    end
    vectors++; if (occ_max !== 1) begin miscompares++; $display("FAIL b2b_occupancy: got %0d want 1", occ_max); end
  endtask

  task automatic test_reset_mid_write;
    int w = 0;
    int stray = 0;
    offer(19'd42, 16'hBEEF, 1'b1);
    step;
    bus.data_ready = 1'b0;
    while (!bus.sram_wr_req && w < 10) begin step; w++; end
    vectors++; if (bus.sram_wr_req !== 1'b1) begin miscompares++; $display("FAIL rst_setup_req: got %b want 1", bus.sram_wr_req); end
    #2 n_rst = 1'b0;
    #1;
    vectors++; if (bus.sram_wr_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b want 0", bus.sram_wr_req); end
    vectors++; if (bus.idle !== 1'b1) begin miscompares++; $display("FAIL rst_idle: got %b want 1", bus.idle); end
    vectors++; if (bus.drop_count !== 8'd0) begin miscompares++; $display("FAIL rst_drop: got %0d want 0", bus.drop_count); end
    vectors++; if (bus.sram_addr !== 20'h0) begin miscompares++; $display("FAIL rst_addr: got %h want 0", bus.sram_addr); end
    vectors++; if (bus.sram_wdata !== 16'h0) begin miscompares++; $display("FAIL rst_wdata: got %h want 0", bus.sram_wdata); end
    step;
    step;
    n_rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step;
      if (bus.sram_wr_req || bus.data_sent || !bus.idle) stray++;
    end
    vectors++; if (stray !== 0) begin miscompares++; $display("FAIL rst_no_resume: got %0d active cycles want 0", stray); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_fill;
    test_out_of_range;
    test_wrap;
    test_back_to_back;
    test_reset_mid_write;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pixel_write_buffer.md
# pixel_write_buffer

Downstream stage of the computational core. Accepts one rasterised pixel at a time (19-bit linear address, 16-bit RGB565 colour, frame-buffer select) over the core's `data_ready`/`data_sent` handshake. Buffers pixels in a small FIFO and drains them to the external SRAM write port with a request/acknowledge handshake. Pixels outside the 640x480 visible range are discarded and counted. Double buffering is handled by prefixing the frame select onto the SRAM address.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; must be a power of 2, at least 2.
- PIX_LIMIT, 307200, first invalid linear pixel address (640*480).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- n_rst  in  1  reset, asynchronous and active-low.
- data_ready  in  1  core has a valid pixel on address/color/frame_target.
- address  in  19  linear pixel address (y*640+x).
- color  in  16  RGB565 pixel colour.
- frame_target  in  1  destination frame buffer, 0 or 1.
- data_sent  out  1  registered one-cycle pulse: pixel taken (stored or dropped).
- sram_wr_req  out  1  write request; held until acknowledged.
- sram_addr  out  20  {frame_target, address} of the head entry.
- sram_wdata  out  16  colour of the head entry.
- sram_wr_ack  in  1  SRAM write done; sampled only while sram_wr_req=1.
- idle  out  1  FIFO empty and no write outstanding; used for frame swap.
- drop_count  out  8  saturating count of discarded out-of-range pixels.

## Operation
- Storage: DEPTH x 36-bit entries ({frame_target, address, color}), with read and write pointers of log2(DEPTH) bits that wrap at DEPTH. Occupancy counter is log2(DEPTH)+1 bits.
- Capture condition at a rising edge: data_ready=1 AND data_sent=0 AND (FIFO not full OR address >= PIX_LIMIT).
  - In range: the entry is pushed.
  - Out of range: the entry is not pushed; drop_count increments and saturates at 255.
  - In both cases data_sent=1 for exactly the next cycle.
- data_ready is ignored while data_sent=1. This prevents double capture and gives at most one pixel every 2 cycles.
- Full FIFO with an in-range pixel: no capture, data_sent stays 0, and the core holds its data. A pop in the same cycle does not free a slot for that cycle's push; the push succeeds on the next edge.
- Writer FSM:
  - IDLE: sram_wr_req=0. If the FIFO is non-empty at the edge, load the head entry into the sram_addr/sram_wdata registers and go to WRITE.
  - WRITE: sram_wr_req=1, address and data stable. When sram_wr_ack=1 at the edge, pop the head and return to IDLE. Otherwise stay in WRITE.
- idle = (occupancy==0) AND (state==IDLE). It is computed combinationally from registers.
- A push and a pop on the same edge leave occupancy unchanged.
- Reset (any time, including mid-write):
  - FIFO empties, pointers and occupancy go to 0, FSM goes to IDLE.
  - data_sent=0, sram_wr_req=0, sram_addr=0, sram_wdata=0, drop_count=0, idle=1.
  - Any pending write is abandoned and not retried.

## Timing
- Acceptance latency: data_ready rises before edge k with the FIFO not full, so data_sent is high during cycle k..k+1.
- Empty FIFO, writer IDLE, push at edge k:
  - Writer sees non-empty at edge k+1.
  - sram_wr_req rises after edge k+1.
  - Pixel-in to request out is 2 edges.
- Ack sampled high at edge m: sram_wr_req is low during cycle m..m+1, and the next request rises after edge m+1. The minimum request spacing is 2 cycles, matching input throughput.
- sram_addr and sram_wdata change only on the IDLE->WRITE transition.
- drop_count updates on the same edge as the corresponding data_sent rise.

## Test plan
- Reset: assert n_rst=0 mid-WRITE, then release. Required: sram_wr_req=0, data_sent=0, idle=1, drop_count=0, and no write resumes afterwards.
- Single pixel: address=19'd200, color=16'h0060, frame_target=1, ack returned 3 cycles after request. Required: one data_sent pulse, then sram_addr=20'h800C8 and sram_wdata=16'h0060 held stable until ack, then idle=1.
- Fill: hold sram_wr_ack=0 and offer 9 in-range pixels. Required: 8 data_sent pulses, with the 9th held (data_sent stays 0). Then pulse ack once. Required: the 9th is accepted 1 cycle after the pop, and the SRAM sees writes in push order.
- Out of range: address=19'd307200, then 19'd524287. Required: both get a data_sent pulse, drop_count=2, no sram_wr_req, idle stays 1. After 300 drops, drop_count=255.
- Wrap-around: stream 20 pixels with incrementing colour, acking each request on its first cycle. Required: 20 writes with colours in order, idle=1 at the end.
- Streaming: data_ready held high with new data after each data_sent, plus immediate ack. Required: one pixel accepted and one write every 2 cycles, and occupancy never exceeds 1.
